tqvp_iraj_vmac: RTL and testbench
=================================

# tqvp_iraj_vmac

Parametrised streaming multiply-accumulate peripheral for the TinyQV peripheral bus. It is the successor to the single-shot INT16 MAC. Software pushes packed operand pairs into a DEPTH-entry FIFO, and a 2-stage pipeline multiplies and accumulates COUNT pairs into an ACC_W-bit accumulator, with configurable signedness, shift, rounding and saturation. Pushes may continue while a run is in progress, so the block accepts data streamed from the CPU.

## Interface
- DATA_W, 16: operand width; legal values 8 or 16.
- ACC_W, 48: accumulator width; legal range 2*DATA_W+2 to 64.
- DEPTH, 8: operand-pair FIFO depth; power of two, 2 to 16.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ui_in  in  8  unused.
- uo_out  out  8  [1]=done, [2]=sat, [3]=busy; all other bits 0.
- address  in  6  register address.
- data_in  in  32  write data.
- data_write_n  in  2  11=none, 00=8b, 01=16b, 10=32b write.
- data_read_n  in  2  read strobe; reads have no side effects.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  constant 1.
- user_interrupt  out  1  done & IRQ_EN.

## Operation
- **Register map.** Partial writes are masked to the low 8/16 bits.
- **0x00 CTRL (RW).**
  - [0] START: W1.
  - [1] SIGNED.
  - [2] SAT_EN.
  - [3] ROUND_EN.
  - [9:4] SHIFT.
  - [10] CLEAR_ACC: W1.
  - [11] IRQ_EN.
  - [12] CLR_DONE: W1.
  - [13] FLUSH: W1.
  - W1 bits are not stored and read back as 0.
- **0x04 COUNT (RW).** [15:0] = number of pairs per run.
- **0x08 PUSH (W).**
  - Only 32-bit writes push the pair A=data_in[DATA_W-1:0], B=data_in[16+DATA_W-1:16]. 8b/16b writes are ignored.
  - Reads return 0.
- **0x0C STATUS (R).**
  - [0] busy, [1] done, [2] sat, [3] overflow.
  - [8+] FIFO level.
  - [31:16] remaining pairs.
- **0x10 ACC_L (R).** acc[31:0].
- **0x14 ACC_H (R).** acc[ACC_W-1:32], sign-extended to 32 bits.
- **0x18 LAST_PROD (R).** Last raw product, sign- or zero-extended per SIGNED.
- **Other addresses.** Read as 0.
- **FSM states.**
  - IDLE: on START, if COUNT=0, set done and stay in IDLE. Otherwise load remaining=COUNT, clear done, go to RUN.
  - RUN: each cycle in which the FIFO is non-empty and remaining>0, pop the head, register the product into stage 1 and decrement remaining. When remaining=0, go to DRAIN.
  - DRAIN: wait one cycle for stage 2 to accumulate, then set done and go to IDLE.
  - An empty FIFO in RUN stalls indefinitely. There is no timeout.
- **Arithmetic.**
  - The product is computed signed or unsigned per SIGNED and extended to ACC_W+1 bits.
  - If SHIFT≠0 and ROUND_EN=1, add 2^(SHIFT-1) before the shift (round half up).
  - Shift is arithmetic right by SHIFT. A shift of ≥ the product width yields 0 or -1.
  - sum = acc + shifted, computed at ACC_W+1 bits.
  - With SAT_EN=1, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat. With SAT_EN=0, wrap to ACC_W bits.
  - sat is sticky until CLEAR_ACC.
- **Control rules.**
  - START, CLEAR_ACC and FLUSH are ignored while busy.
  - CLEAR_ACC zeroes acc and sat and does not set done.
  - FLUSH empties the FIFO and clears overflow.
  - CLR_DONE clears done. If START and CLR_DONE are written together, START wins.
- **Push while full.**
  - If a pop occurs in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the pair is discarded and overflow is set (sticky until FLUSH).

## Timing
- **Reset.** All registers, FIFO pointers, level, state and flags are 0. All outputs are 0 except data_ready=1.
  - Reset mid-run aborts the run and empties the FIFO.
- **Write capture.** A write is captured at the clock edge on which it is presented (edge E0).
- **Run latency.**
  - busy=1 after E0.
  - With N pairs already queued, pops occur at E1..EN and the last accumulate occurs at EN+1.
  - done=1 and busy=0 after EN+2.
- **Throughput.** One pair per cycle when the FIFO never runs empty.
- **Streaming.** A pair pushed at edge Ep can be popped at Ep+1 at the earliest.
- **Interrupt.** user_interrupt follows done and IRQ_EN combinationally, with no extra delay.

## Test plan
- **Signed dot product.** DATA_W=16, SIGNED=1. Push (3,-4), (1000,2000), (-7,-7); COUNT=3; START with IRQ_EN=1.
  - ACC_L=2000037, ACC_H=0.
  - done and user_interrupt assert 5 cycles after the START edge.
- **Rounding.** Unsigned (7,3) with SHIFT=2 and ROUND_EN=1 gives +5.
  - Then signed (-7,3) with the same shift and round, accumulating onto the previous result, gives acc=0 (-21 rounds to -5).
- **Saturation.** ACC_W=34, SAT_EN=1, unsigned. Push (65535,65535) three times; COUNT=3.
  - acc=0x1_FFFF_FFFF and sat=1.
  - CLEAR_ACC then gives acc=0 and sat=0.
- **Overflow.** DEPTH=8, idle. Push 9 pairs.
  - level=8 and overflow=1.
  - FLUSH gives level=0 and overflow=0.
- **Stall.** COUNT=2, START with an empty FIFO.
  - busy stays 1 for 10 cycles.
  - Push (2,3) then (4,5): acc=26, and done asserts 3 cycles after the second push edge.
- **Reset mid-run and COUNT=0.** Assert rst_n low mid-run: all outputs reset immediately.
  - START with COUNT=0: done is set at the next edge and busy never asserts.

Source files
------------

// File: rtl/tqvp_iraj_vmac.sv
// Streaming multiply-accumulate peripheral: operand FIFO feeding a 2-stage MAC.
module tqvp_iraj_vmac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int unsigned PRW = 2 * DATA_W;
  localparam int unsigned PW  = ACC_W + 1;
  localparam int unsigned XW  = 66;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state;
  logic                signed_mode, sat_en, round_en, irq_en;
  logic [5:0]          shift;
  logic [15:0]         count_q, remaining;
  logic                done, sat, ovf;
  logic [ACC_W-1:0]    acc;
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [LW-1:0]       level;
  logic                s1_valid;
  logic [PW-1:0]       s1_ext;
  logic [PRW-1:0]      last_prod;

  logic [DATA_W-1:0]   mem_a [DEPTH];
  logic [DATA_W-1:0]   mem_b [DEPTH];

  logic [31:0]         wdata;
  logic                wr_en, ctrl_wr, count_wr, push_req, busy;
  logic                start, clear_acc, flush, clr_done;
  logic                fifo_full, fifo_empty, pop, push_ok, push_drop;
  logic [PRW-1:0]      op_a, op_b, prod;
  logic [PW-1:0]       prod_ext;
  logic [XW-1:0]       xw_in, rnd;
  logic signed [XW-1:0] rounded, shifted_x;
  logic [PW-1:0]       shifted, sum;
  logic                sat_hit;
  logic [ACC_W-1:0]    acc_next;

  // Write decode: partial writes carry only their low 8/16 bits
  always_comb begin
    case (data_write_n)
      2'b00:   wdata = {24'b0, data_in[7:0]};
      2'b01:   wdata = {16'b0, data_in[15:0]};
      default: wdata = data_in;
    endcase
  end

  assign wr_en      = (data_write_n != 2'b11);
  assign ctrl_wr    = wr_en && (address == 6'h00);
  assign count_wr   = wr_en && (address == 6'h04);
  assign push_req   = (data_write_n == 2'b10) && (address == 6'h08);
  assign busy       = (state != S_IDLE);
  assign start      = ctrl_wr && !busy && wdata[0];
  assign clear_acc  = ctrl_wr && !busy && wdata[10];
  assign flush      = ctrl_wr && !busy && wdata[13];
  assign clr_done   = ctrl_wr && wdata[12];
  assign fifo_full  = (level == LW'(DEPTH));
  assign fifo_empty = (level == '0);
  assign pop        = (state == S_RUN) && !fifo_empty && (remaining != 16'd0);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign push_drop  = push_req && fifo_full && !pop;

  // Stage-1 multiply of the FIFO head, signedness chosen at pop time
  always_comb begin
    op_a     = {{DATA_W{signed_mode & mem_a[rd_ptr][DATA_W-1]}}, mem_a[rd_ptr]};
    op_b     = {{DATA_W{signed_mode & mem_b[rd_ptr][DATA_W-1]}}, mem_b[rd_ptr]};
    prod     = op_a * op_b;
    prod_ext = {{(PW-PRW){signed_mode & prod[PRW-1]}}, prod};
  end

  // Stage-2 round, arithmetic shift, accumulate and optional clamp
  always_comb begin
    xw_in     = {{(XW-PW){s1_ext[PW-1]}}, s1_ext};
    rnd       = (round_en && (shift != 6'd0)) ? (XW'(1) << (shift - 6'd1)) : '0;
    rounded   = xw_in + rnd;
    shifted_x = rounded >>> shift;
    shifted   = shifted_x[PW-1:0];
    sum       = {acc[ACC_W-1], acc} + shifted;
    sat_hit   = sat_en && (sum[ACC_W] ^ sum[ACC_W-1]);
    acc_next  = sum[ACC_W-1:0];
    if (sat_hit) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Operand storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_a[wr_ptr] <= data_in[DATA_W-1:0];
      mem_b[wr_ptr] <= data_in[16 +: DATA_W];
    end
  end

  // Control FSM, configuration, FIFO bookkeeping and MAC pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      signed_mode <= 1'b0;
      sat_en      <= 1'b0;
      round_en    <= 1'b0;
      irq_en      <= 1'b0;
      shift       <= 6'd0;
      count_q     <= 16'd0;
      remaining   <= 16'd0;
      done        <= 1'b0;
      sat         <= 1'b0;
      ovf         <= 1'b0;
      acc         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      s1_valid    <= 1'b0;
      s1_ext      <= '0;
      last_prod   <= '0;
    end else begin
      if (ctrl_wr) begin
        signed_mode <= wdata[1];
        sat_en      <= wdata[2];
        round_en    <= wdata[3];
        shift       <= wdata[9:4];
        irq_en      <= wdata[11];
      end
      if (count_wr) count_q <= wdata[15:0];
      if (clr_done) done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (count_q == 16'd0) begin
              done <= 1'b1;
            end else begin
              remaining <= count_q;
              done      <= 1'b0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pop) remaining <= remaining - 16'd1;
          if (remaining == 16'd0) state <= S_DRAIN;
        end
        S_DRAIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      level <= level + LW'(1);
        else if (pop && !push_ok) level <= level - LW'(1);
        if (push_drop) ovf <= 1'b1;
      end

      s1_valid <= pop;
      if (pop) begin
        s1_ext    <= prod_ext;
        last_prod <= prod;
      end

      if (clear_acc) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_next;
        if (sat_hit) sat <= 1'b1;
      end
    end
  end

  // Register read mux
  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h00: data_out = {20'b0, irq_en, 1'b0, shift, round_en, sat_en, signed_mode, 1'b0};
      6'h04: data_out = {16'b0, count_q};
      6'h0C: data_out = {remaining, 8'(level), 4'b0, ovf, sat, done, busy};
      6'h10: data_out = acc[31:0];
      6'h14: data_out = 32'($signed(acc) >>> 32);
      6'h18: data_out = signed_mode ? 32'($signed(last_prod)) : 32'(last_prod);
      default: data_out = 32'd0;
    endcase
  end

  assign uo_out         = {4'b0, busy, sat, done, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = done & irq_en;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, data_read_n, wdata, shifted_x};

endmodule

// File: tb/tb_tqvp_iraj_vmac.sv
// Directed self-checking bench for tqvp_iraj_vmac (default build plus ACC_W=34 build).
module tb_tqvp_iraj_vmac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'd0;
  logic [5:0]  address = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;

  logic [7:0]  uo_out, uo_out34;
  logic [31:0] data_out, data_out34;
  logic        data_ready, data_ready34;
  logic        irq, irq34;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] SZ8 = 2'b00, SZ16 = 2'b01, SZ32 = 2'b10;
  localparam logic [5:0] A_CTRL = 6'h00, A_COUNT = 6'h04, A_PUSH = 6'h08, A_STAT = 6'h0C,
                         A_ACCL = 6'h10, A_ACCH = 6'h14, A_LAST = 6'h18;

  tqvp_iraj_vmac dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(irq)
  );

  tqvp_iraj_vmac #(.DATA_W(16), .ACC_W(34), .DEPTH(8)) dut34 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out34),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out34), .data_ready(data_ready34),
    .user_interrupt(irq34)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address      = a;
    data_in      = d;
    data_write_n = sz;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    wr(A_PUSH, {b, a}, SZ32);
  endtask

  task automatic chk_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a; #1;
    check(tag, 64'(data_out), 64'(exp));
  endtask

  task automatic chk_reg34(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a; #1;
    check(tag, 64'(data_out34), 64'(exp));
  endtask

  // Returns edges elapsed until done, or -1 after the budget expires
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (uo_out[1]) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    int busy_cnt;

    // Reset values
    #1;
    check("rst_uo_out", 64'(uo_out), 64'h0);
    check("rst_ready", 64'(data_ready), 64'h1);
    check("rst_irq", 64'(irq), 64'h0);
    chk_reg("rst_status", A_STAT, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed dot product with interrupt
    push(16'd3, 16'hFFFC);
    push(16'd1000, 16'd2000);
    push(16'hFFF9, 16'hFFF9);
    wr(A_COUNT, 32'd3, SZ16);
    wr(A_CTRL, 32'h803, SZ16);
    check("dot_busy_after_start", 64'(uo_out[3]), 64'h1);
    repeat (4) begin @(posedge clk); #1; end
    check("dot_not_done_e4", 64'(uo_out[1]), 64'h0);
    @(posedge clk); #1;
    check("dot_uo_done_e5", 64'(uo_out), 64'h02);
    check("dot_irq_e5", 64'(irq), 64'h1);
    chk_reg("dot_acc_l", A_ACCL, 32'd2000037);
    chk_reg("dot_acc_h", A_ACCH, 32'd0);
    chk_reg("dot_last_prod", A_LAST, 32'd49);
    chk_reg("dot_status", A_STAT, 32'h2);
    chk_reg("dot_ctrl_rb", A_CTRL, 32'h802);
    wr(A_CTRL, 32'h1802, SZ16);
    check("clr_done_uo", 64'(uo_out), 64'h0);
    check("clr_done_irq", 64'(irq), 64'h0);

    // Rounding: unsigned then signed, accumulating onto each other
    wr(A_CTRL, 32'h400, SZ16);
    chk_reg("clear_acc", A_ACCL, 32'd0);
    push(16'd7, 16'd3);
    wr(A_COUNT, 32'd1, SZ16);
    wr(A_CTRL, 32'h29, SZ16);
    wait_done(cyc);
    check("round_n1_latency", 64'(cyc), 64'd3);
    chk_reg("round_unsigned", A_ACCL, 32'd5);
    push(16'hFFF9, 16'd3);
    wr(A_CTRL, 32'h2B, SZ16);
    wait_done(cyc);
    chk_reg("round_signed_l", A_ACCL, 32'd0);
    chk_reg("round_signed_h", A_ACCH, 32'd0);
    chk_reg("round_last_prod", A_LAST, 32'hFFFF_FFEB);

    // Saturation on the 34-bit accumulator, wrap-free growth on the 48-bit one
    wr(A_CTRL, 32'h400, SZ16);
    repeat (3) push(16'hFFFF, 16'hFFFF);
    wr(A_COUNT, 32'd3, SZ16);
    wr(A_CTRL, 32'h5, SZ16);
    wait_done(cyc);
    chk_reg34("sat34_acc_l", A_ACCL, 32'hFFFF_FFFF);
    chk_reg34("sat34_acc_h", A_ACCH, 32'h1);
    check("sat34_flag", 64'(uo_out34[2]), 64'h1);
    chk_reg("sat48_acc_l", A_ACCL, 32'hFFFA_0003);
    chk_reg("sat48_acc_h", A_ACCH, 32'h2);
    check("sat48_flag", 64'(uo_out[2]), 64'h0);
    wr(A_CTRL, 32'h400, SZ16);
    chk_reg34("sat34_cleared_acc", A_ACCL, 32'h0);
    check("sat34_cleared_flag", 64'(uo_out34[2]), 64'h0);

    // Overflow while idle, then FLUSH
    wr(A_PUSH, 32'h0001_0001, SZ8);
    chk_reg("push_8b_ignored", A_STAT, 32'h2);
    repeat (9) push(16'd1, 16'd1);
    chk_reg("ovf_status", A_STAT, 32'h0000_080A);
    wr(A_CTRL, 32'h2000, SZ16);
    chk_reg("flush_status", A_STAT, 32'h2);

    // Push into a full FIFO on the same cycle as a pop is accepted
    repeat (8) push(16'd1, 16'd1);
    wr(A_COUNT, 32'd9, SZ16);
    wr(A_CTRL, 32'h1, SZ16);
    push(16'd1, 16'd1);
    address = A_STAT; #1;
    check("full_pop_push_ovf", 64'(data_out[3]), 64'h0);
    check("full_pop_push_level", 64'(data_out[15:8]), 64'd8);
    wait_done(cyc);
    chk_reg("full_pop_push_acc", A_ACCL, 32'd9);

    // Stall with an empty FIFO, then stream two pairs in
    wr(A_CTRL, 32'h400, SZ16);
    wr(A_COUNT, 32'd2, SZ16);
    wr(A_CTRL, 32'h1, SZ16);
    busy_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (uo_out[3]) busy_cnt++;
    end
    check("stall_busy_cycles", 64'(busy_cnt), 64'd10);
    chk_reg("stall_status", A_STAT, 32'h0002_0001);
    push(16'd2, 16'd3);
    push(16'd4, 16'd5);
    wait_done(cyc);
    check("stall_done_latency", 64'(cyc), 64'd3);
    chk_reg("stall_acc", A_ACCL, 32'd26);

    // Reset mid-run
    push(16'd1, 16'd1);
    push(16'd1, 16'd1);
    wr(A_COUNT, 32'd5, SZ16);
    wr(A_CTRL, 32'h801, SZ16);
    repeat (4) begin @(posedge clk); #1; end
    check("midrun_busy", 64'(uo_out[3]), 64'h1);
    address = A_STAT;
    rst_n = 1'b0; #1;
    check("midrun_rst_uo", 64'(uo_out), 64'h0);
    check("midrun_rst_status", 64'(data_out), 64'h0);
    check("midrun_rst_irq", 64'(irq), 64'h0);
    chk_reg("midrun_rst_acc", A_ACCL, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START with COUNT=0
    wr(A_COUNT, 32'd0, SZ16);
    wr(A_CTRL, 32'h1, SZ16);
    check("count0_uo", 64'(uo_out), 64'h02);
    busy_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (uo_out[3]) busy_cnt++;
    end
    check("count0_never_busy", 64'(busy_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
